box_lock_ctrl: RTL and testbench
================================

Name: box_lock_ctrl

Overview:
Sequential lock controller that sits directly downstream of the door-button debouncer. It consumes the debouncer's one-cycle key_pulse together with the 4-bit code switches {q,u,n,b} and decides whether to open, raise an alarm, or lock out. Open and alarm states are timed, and consecutive failures are counted. It drives the active-low open/alarm LEDs.

Parameters:
SECRET, 4'b0111, code that opens the box
OPEN_CYCLES, 24, clock cycles the open state is held (>=1)
ALARM_CYCLES, 12, clock cycles the alarm state is held (>=1)
LOCK_CYCLES, 48, clock cycles the lockout state is held (>=1)
MAX_FAIL, 3, consecutive failures that trigger lockout (1..7)
CNT_W, 18, timer width; each *_CYCLES value must be <= 2^CNT_W

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
code  input  4  code switches {q,u,n,b}, static between presses
key_pulse  input  1  one-cycle pulse from debouncer = one door-button press
led1  output  1  open LED, active-low (0 = open)
led2  output  1  alarm LED, active-low (0 = alarm)
locked  output  1  high while in LOCKOUT
fail_cnt  output  3  current consecutive-failure count
busy  output  1  high in any state other than IDLE

Behaviour:
- One clock; reset is synchronous and active-high. rst is sampled on the rising edge of clk and overrides all other inputs.
- Reset values: state=IDLE, timer=0, fail_cnt=0, led1=1, led2=1, locked=0, busy=0.
- States: IDLE, OPEN, ALARM, LOCKOUT. All outputs are registered and decoded from the next state, so they change on the same edge as the state.
- IDLE with key_pulse=1 (code is sampled on that same edge):
  - code==SECRET: go to OPEN; fail_cnt<=0; timer<=OPEN_CYCLES-1.
  - code!=SECRET and fail_cnt+1 < MAX_FAIL: go to ALARM; fail_cnt<=fail_cnt+1; timer<=ALARM_CYCLES-1.
  - code!=SECRET and fail_cnt+1 == MAX_FAIL: go to LOCKOUT; fail_cnt<=MAX_FAIL; timer<=LOCK_CYCLES-1.
- IDLE with key_pulse=0: hold.
- OPEN, ALARM, LOCKOUT:
  - timer decrements by 1 each cycle.
  - When timer==0, return to IDLE on that edge. Each state is therefore asserted for exactly N cycles.
  - Exiting LOCKOUT clears fail_cnt to 0.
  - Exiting OPEN or ALARM leaves fail_cnt unchanged.
- key_pulse while not in IDLE is ignored and is not queued. A pulse arriving on the same edge as a timed state's exit is also ignored.
- Output decode:
  - led1=0 only in OPEN.
  - led2=0 in ALARM and in LOCKOUT.
  - locked=1 only in LOCKOUT.
  - busy=1 whenever state!=IDLE.
- Latency: pulse sampled at edge k; outputs reflect the new state immediately after edge k. The first OPEN/ALARM cycle is the cycle following edge k.
- Timer arithmetic is unsigned CNT_W bits and never wraps, because it is reloaded before it can underflow.
- fail_cnt saturates at MAX_FAIL.
- Reset mid-operation (any state, any timer value): next edge returns to the full reset values. The failure history is lost.
- A code change while busy has no effect; code is only sampled on an accepted pulse.

Test Plan:
1. Reset with rst=1 for 2 cycles, then idle for 10 cycles -> led1=1, led2=1, locked=0, fail_cnt=0, busy=0 throughout.
2. code=4'b0111 with a single key_pulse -> led1=0 for exactly 24 cycles starting the cycle after the pulse, then led1=1; fail_cnt=0; led2 stays 1.
3. code=4'b0000 with a pulse, wait for return to IDLE, then code=4'b0111 with a pulse:
   - first pulse: led2=0 for exactly 12 cycles, fail_cnt=1;
   - second pulse: OPEN for 24 cycles, fail_cnt=0.
4. Three wrong pulses, each issued after returning to IDLE:
   - fail_cnt goes 1, 2;
   - the third pulse enters LOCKOUT: locked=1 and led2=0 for 48 cycles, fail_cnt=3;
   - on exit: fail_cnt=0, locked=0.
5. During LOCKOUT, pulse with code=4'b0111 at cycle 10 and again on the final cycle -> both ignored; led1 stays 1; LOCKOUT length is still 48 cycles.
6. Enter OPEN, assert rst for 1 cycle at timer cycle 5 -> next edge shows led1=1, busy=0, fail_cnt=0; a subsequent correct pulse gives a full 24-cycle OPEN.

Source files
------------

// File: rtl/box_lock_ctrl.sv
// rtl/box_lock_ctrl.sv - timed open/alarm/lockout controller driven by debounced key pulses
module box_lock_ctrl #(
    parameter logic [3:0] SECRET       = 4'b0111,
    parameter int         OPEN_CYCLES  = 24,
    parameter int         ALARM_CYCLES = 12,
    parameter int         LOCK_CYCLES  = 48,
    parameter int         MAX_FAIL     = 3,
    parameter int         CNT_W        = 18
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] code,
    input  logic       key_pulse,
    output logic       led1,
    output logic       led2,
    output logic       locked,
    output logic [2:0] fail_cnt,
    output logic       busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_OPEN  = 2'd1,
        S_ALARM = 2'd2,
        S_LOCK  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] OPEN_LOAD  = CNT_W'(OPEN_CYCLES - 1);
    localparam logic [CNT_W-1:0] ALARM_LOAD = CNT_W'(ALARM_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCK_LOAD  = CNT_W'(LOCK_CYCLES - 1);
    localparam logic [3:0]       FAIL_LIMIT = 4'(MAX_FAIL);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [2:0]       fail_q, fail_d;
    logic [3:0]       fail_inc;

    // One extra bit so the compare against MAX_FAIL cannot overflow at 7.
    assign fail_inc = {1'b0, fail_q} + 4'd1;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        fail_d  = fail_q;
        case (state_q)
            S_IDLE: begin
                if (key_pulse) begin
                    if (code == SECRET) begin
                        state_d = S_OPEN;
                        timer_d = OPEN_LOAD;
                        fail_d  = 3'd0;
                    end else if (fail_inc < FAIL_LIMIT) begin
                        state_d = S_ALARM;
                        timer_d = ALARM_LOAD;
                        fail_d  = fail_inc[2:0];
                    end else begin
                        state_d = S_LOCK;
                        timer_d = LOCK_LOAD;
                        fail_d  = FAIL_LIMIT[2:0];
                    end
                end
            end
            default: begin
                // Timed states ignore key_pulse entirely, including on the exit edge.
                if (timer_q == '0) begin
                    state_d = S_IDLE;
                    if (state_q == S_LOCK) begin
                        fail_d = 3'd0;
                    end
                end else begin
                    timer_d = timer_q - CNT_W'(1);
                end
            end
        endcase
    end

    // Outputs are decoded from the next state so they move on the same edge as the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            fail_q  <= 3'd0;
            led1    <= 1'b1;
            led2    <= 1'b1;
            locked  <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            fail_q  <= fail_d;
            led1    <= (state_d != S_OPEN);
            led2    <= !((state_d == S_ALARM) || (state_d == S_LOCK));
            locked  <= (state_d == S_LOCK);
            busy    <= (state_d != S_IDLE);
        end
    end

    assign fail_cnt = fail_q;

endmodule

// File: tb/tb_box_lock_ctrl.sv
// tb/tb_box_lock_ctrl.sv - self-checking bench for box_lock_ctrl against an elapsed-time model
module tb_box_lock_ctrl;

    localparam logic [3:0] SECRET = 4'b0111;
    localparam int N_OPEN  = 24;
    localparam int N_ALARM = 12;
    localparam int N_LOCK  = 48;
    localparam int N_FAIL  = 3;
    localparam int M_IDLE = 0, M_OPEN = 1, M_ALARM = 2, M_LOCK = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] code = 4'b0000;
    logic       key_pulse = 1'b0;
    logic       led1, led2, locked, busy;
    logic [2:0] fail_cnt;

    int total = 0;
    int bad = 0;

    // Model: an accepted press at edge t occupies the cycles up to and including edge t+N.
    int edge_n = 0;
    int m_mode = M_IDLE;
    int m_until = 0;
    int m_fail = 0;

    box_lock_ctrl dut (
        .clk(clk), .rst(rst), .code(code), .key_pulse(key_pulse),
        .led1(led1), .led2(led2), .locked(locked), .fail_cnt(fail_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] exp_vec();
        return {m_mode != M_OPEN, !(m_mode == M_ALARM || m_mode == M_LOCK),
                m_mode == M_LOCK, m_mode != M_IDLE, 3'(m_fail)};
    endfunction

    function automatic logic [6:0] act_vec();
        return {led1, led2, locked, busy, fail_cnt};
    endfunction

    task automatic model_edge(input logic r, input logic kp, input logic [3:0] c);
        edge_n++;
        if (r) begin
            m_mode = M_IDLE; m_fail = 0; m_until = 0;
        end else if (m_mode == M_IDLE) begin
            if (kp) begin
                if (c == SECRET) begin
                    m_mode = M_OPEN; m_until = edge_n + N_OPEN; m_fail = 0;
                end else if (m_fail + 1 < N_FAIL) begin
                    m_mode = M_ALARM; m_until = edge_n + N_ALARM; m_fail = m_fail + 1;
                end else begin
                    m_mode = M_LOCK; m_until = edge_n + N_LOCK; m_fail = N_FAIL;
                end
            end
        end else if (edge_n == m_until) begin
            if (m_mode == M_LOCK) m_fail = 0;
            m_mode = M_IDLE;
        end
    endtask

    task automatic step(input logic r, input logic kp, input logic [3:0] c);
        rst = r; key_pulse = kp; code = c;
        @(posedge clk);
        model_edge(r, kp, c);
        #1;
        key_pulse = 1'b0;
    endtask

    function automatic logic [3:0] wrong_code();
        logic [3:0] c;
        c = 4'($urandom_range(0, 15));
        if (c == SECRET) c = ~c;
        return c;
    endfunction

    task automatic test_reset();
        for (int i = 0; i < 12; i++) begin
            step(i < 2, 1'b0, 4'b0000);
            total++;
            if (act_vec() !== 7'b1100000) begin
                bad++;
                $display("FAIL reset cyc=%0d got=%b want=%b", i, act_vec(), 7'b1100000);
            end
        end
    endtask

    task automatic test_open();
        int low = 0;
        step(1'b0, 1'b1, SECRET);
        total++;
        if (led1 !== 1'b0) begin
            bad++; $display("FAIL open_first led1 got=%b want=0", led1);
        end
        low += (led1 == 1'b0);
        for (int i = 0; i < 30; i++) begin
            step(1'b0, 1'b0, SECRET);
            low += (led1 == 1'b0);
            total++;
            if (act_vec() !== exp_vec()) begin
                bad++; $display("FAIL open cyc=%0d got=%b want=%b", i, act_vec(), exp_vec());
            end
        end
        total++;
        if (low != N_OPEN) begin
            bad++; $display("FAIL open_len got=%0d want=%0d", low, N_OPEN);
        end
    endtask

    task automatic test_alarm_then_open();
        int low2 = 0;
        int low1 = 0;
        step(1'b0, 1'b1, 4'b0000);
        low2 += (led2 == 1'b0);
        total++;
        if (fail_cnt !== 3'd1) begin
            bad++; $display("FAIL alarm_fail got=%0d want=1", fail_cnt);
        end
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0, 4'b0000);
            low2 += (led2 == 1'b0);
            total++;
            if (act_vec() !== exp_vec()) begin
                bad++; $display("FAIL alarm cyc=%0d got=%b want=%b", i, act_vec(), exp_vec());
            end
        end
        total++;
        if (low2 != N_ALARM) begin
            bad++; $display("FAIL alarm_len got=%0d want=%0d", low2, N_ALARM);
        end
        step(1'b0, 1'b1, SECRET);
        low1 += (led1 == 1'b0);
        for (int i = 0; i < 30; i++) begin
            step(1'b0, 1'b0, SECRET);
            low1 += (led1 == 1'b0);
            total++;
            if (act_vec() !== exp_vec()) begin
                bad++; $display("FAIL reopen cyc=%0d got=%b want=%b", i, act_vec(), exp_vec());
            end
        end
        total++;
        if (low1 != N_OPEN || fail_cnt !== 3'd0) begin
            bad++; $display("FAIL reopen_len got=%0d/%0d want=%0d/0", low1, fail_cnt, N_OPEN);
        end
    endtask

    task automatic enter_lockout(input string tag);
        for (int k = 0; k < N_FAIL; k++) begin
            step(1'b0, 1'b1, wrong_code());
            total++;
            if (fail_cnt !== 3'(k + 1) || act_vec() !== exp_vec()) begin
                bad++; $display("FAIL %s_fail%0d got=%b want=%b", tag, k, act_vec(), exp_vec());
            end
            if (k < N_FAIL - 1) begin
                for (int i = 0; i < 100 && busy; i++) step(1'b0, 1'b0, 4'b0000);
                total++;
                if (busy !== 1'b0) begin
                    bad++; $display("FAIL %s_wait_idle busy got=%b want=0", tag, busy);
                end
            end
        end
    endtask

    task automatic test_lockout();
        int nlock;
        enter_lockout("lock");
        nlock = (locked == 1'b1 && led2 == 1'b0);
        for (int i = 0; i < 60; i++) begin
            step(1'b0, 1'b0, 4'b0000);
            nlock += (locked == 1'b1 && led2 == 1'b0);
            total++;
            if (act_vec() !== exp_vec()) begin
                bad++; $display("FAIL lock cyc=%0d got=%b want=%b", i, act_vec(), exp_vec());
            end
        end
        total++;
        if (nlock != N_LOCK || fail_cnt !== 3'd0 || locked !== 1'b0) begin
            bad++; $display("FAIL lock_exit len=%0d fail=%0d locked=%b want %0d/0/0",
                            nlock, fail_cnt, locked, N_LOCK);
        end
    endtask

    task automatic test_lockout_ignore();
        int nlock;
        int nopen = 0;
        enter_lockout("ign");
        nlock = locked;
        for (int j = 1; j <= 60; j++) begin
            step(1'b0, (j == 10) || (j == N_LOCK), SECRET);
            nlock += locked;
            nopen += (led1 == 1'b0);
            total++;
            if (act_vec() !== exp_vec()) begin
                bad++; $display("FAIL ignore cyc=%0d got=%b want=%b", j, act_vec(), exp_vec());
            end
        end
        total++;
        if (nlock != N_LOCK || nopen != 0) begin
            bad++; $display("FAIL ignore_len lock=%0d open=%0d want %0d/0", nlock, nopen, N_LOCK);
        end
    endtask

    task automatic test_reset_mid();
        int low = 0;
        step(1'b0, 1'b1, SECRET);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, SECRET);
        step(1'b1, 1'b0, SECRET);
        total++;
        if (act_vec() !== 7'b1100000 || act_vec() !== exp_vec()) begin
            bad++; $display("FAIL reset_mid got=%b want=%b", act_vec(), 7'b1100000);
        end
        step(1'b0, 1'b1, SECRET);
        low += (led1 == 1'b0);
        for (int i = 0; i < 30; i++) begin
            step(1'b0, 1'b0, SECRET);
            low += (led1 == 1'b0);
        end
        total++;
        if (low != N_OPEN) begin
            bad++; $display("FAIL reset_mid_open got=%0d want=%0d", low, N_OPEN);
        end
    endtask

    task automatic test_random();
        logic r, kp;
        logic [3:0] c;
        for (int i = 0; i < 3000; i++) begin
            r  = ($urandom_range(0, 299) == 0);
            kp = ($urandom_range(0, 5) == 0);
            c  = ($urandom_range(0, 2) == 0) ? SECRET : 4'($urandom_range(0, 15));
            step(r, kp, c);
            total++;
            if (act_vec() !== exp_vec()) begin
                bad++; $display("FAIL random cyc=%0d got=%b want=%b", i, act_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_open();
        test_alarm_then_open();
        test_lockout();
        test_lockout_ignore();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
